// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-side and dispatch-side signals of the decode buffer.
//   flush                      discard everything buffered
//   in_valid / in_ready        fetch packet handshake
//   in_instr, in_mask, in_pc   packet payload; lane 0 is the oldest
//   out_valid / out_ready      dispatch handshake for the head micro-op
//   out_*                      decoded fields of the head micro-op
//   count                      occupied entries
// The buffer uses the slave modport; the fetch/dispatch environment uses master.
interface decode_buffer_if #(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [32*FETCH_W-1:0]  in_instr;
    logic [FETCH_W-1:0]     in_mask;
    logic [31:0]            in_pc;

    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [5:0]             out_operation;
    logic [3:0]             out_rs_station;
    logic [5:0]             out_alu_fn;
    logic [4:0]             out_reg_target;
    logic [4:0]             out_reg_1;
    logic [4:0]             out_reg_2;
    logic                   out_has_target;
    logic                   out_has_reg_1;
    logic                   out_has_reg_2;
    logic [15:0]            out_immediate;
    logic [CNT_W-1:0]       count;

    modport master (
        output flush, in_valid, in_instr, in_mask, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_operation, out_rs_station, out_alu_fn,
               out_reg_target, out_reg_1, out_reg_2, out_has_target, out_has_reg_1,
               out_has_reg_2, out_immediate, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_mask, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_operation, out_rs_station, out_alu_fn,
               out_reg_target, out_reg_1, out_reg_2, out_has_target, out_has_reg_1,
               out_has_reg_2, out_immediate, count
    );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer: multi-lane decode stage feeding a DEPTH-entry circular micro-op queue.
// Every lane of an accepted fetch packet is decoded combinationally; no-ops and
// masked lanes are dropped and the survivors are packed in program order at the
// write pointer. The head entry is presented to dispatch one per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (empties the queue)
//   bus    decode_buffer_if.slave: fetch packet in, head micro-op out, count
module decode_buffer #(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  operation;
        logic [3:0]  rs_station;
        logic [5:0]  alu_fn;
        logic [4:0]  reg_target;
        logic [4:0]  reg_1;
        logic [4:0]  reg_2;
        logic        has_target;
        logic        has_reg_1;
        logic        has_reg_2;
        logic [15:0] immediate;
    } uop_t;

    function automatic uop_t decode_lane(input logic [31:0] instr, input logic [31:0] pc);
        uop_t       u;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        rs          = instr[25:21];
        rt          = instr[20:16];
        rd          = instr[15:11];
        u           = '0;
        u.pc        = pc;
        u.operation = instr[31:26];
        case (instr[31:26])
            6'b001001, 6'b001100, 6'b100011: begin // addiu, andi, lw
                u.rs_station = (instr[31:26] == 6'b100011) ? 4'd4 : 4'd1;
                u.alu_fn     = (instr[31:26] == 6'b001100) ? 6'd2 : 6'd0;
                u.reg_1      = rs;
                u.has_reg_1  = 1'b1;
                u.reg_target = rt;
                u.has_target = 1'b1;
                u.immediate  = instr[15:0];
            end
            6'b000100, 6'b101011: begin // beq, sw
                u.rs_station = (instr[31:26] == 6'b000100) ? 4'd3 : 4'd4;
                u.alu_fn     = (instr[31:26] == 6'b000100) ? 6'd3 : 6'd1;
                u.reg_1      = rs;
                u.has_reg_1  = 1'b1;
                u.reg_2      = rt;
                u.has_reg_2  = 1'b1;
                u.immediate  = instr[15:0];
            end
            6'b001111: begin // lui
                u.rs_station = 4'd3;
                u.reg_target = rt;
                u.has_target = 1'b1;
                u.immediate  = instr[15:0];
            end
            6'b000000: begin
                case (instr[5:0])
                    6'b100001, 6'b100100: begin // addu, and
                        u.rs_station = 4'd1;
                        u.alu_fn     = (instr[5:0] == 6'b100100) ? 6'd1 : 6'd0;
                        u.reg_1      = rs;
                        u.has_reg_1  = 1'b1;
                        u.reg_2      = rt;
                        u.has_reg_2  = 1'b1;
                        u.reg_target = rd;
                        u.has_target = 1'b1;
                    end
                    6'b011010: begin // div writes hi/lo, not a GPR
                        u.rs_station = 4'd2;
                        u.reg_1      = rs;
                        u.has_reg_1  = 1'b1;
                        u.reg_2      = rt;
                        u.has_reg_2  = 1'b1;
                    end
                    6'b010000, 6'b010010: begin // mfhi, mflo
                        u.rs_station = 4'd2;
                        u.alu_fn     = (instr[5:0] == 6'b010010) ? 6'd2 : 6'd1;
                        u.reg_target = rd;
                        u.has_target = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return u;
    endfunction

    uop_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    uop_t             lane_uop  [FETCH_W];
    logic [PTR_W-1:0] lane_slot [FETCH_W];
    logic [FETCH_W-1:0] lane_kept;
    logic [CNT_W-1:0] num_kept;
    logic             accept;
    logic             pop;
    uop_t             head;

    // Each kept lane lands at the write pointer plus the number of kept lanes before it.
    always_comb begin
        num_kept = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_uop[i]  = decode_lane(bus.in_instr[32*i +: 32], bus.in_pc + 32'(4 * i));
            lane_kept[i] = bus.in_mask[i] && (lane_uop[i].rs_station != 4'd0) &&
                           !(lane_uop[i].has_target && (lane_uop[i].reg_target == 5'd0));
            lane_slot[i] = wr_ptr_q + num_kept[PTR_W-1:0];
            if (lane_kept[i]) begin
                num_kept = num_kept + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign bus.out_valid = (count_q != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + num_kept[PTR_W-1:0];
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (accept ? num_kept : '0) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately unreset; only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (accept && !bus.flush) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (lane_kept[i]) begin
                    mem[lane_slot[i]] <= lane_uop[i];
                end
            end
        end
    end

    assign head               = mem[rd_ptr_q];
    assign bus.out_pc         = head.pc;
    assign bus.out_operation  = head.operation;
    assign bus.out_rs_station = head.rs_station;
    assign bus.out_alu_fn     = head.alu_fn;
    assign bus.out_reg_target = head.reg_target;
    assign bus.out_reg_1      = head.reg_1;
    assign bus.out_reg_2      = head.reg_2;
    assign bus.out_has_target = head.has_target;
    assign bus.out_has_reg_1  = head.has_reg_1;
    assign bus.out_has_reg_2  = head.has_reg_2;
    assign bus.out_immediate  = head.immediate;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [5:0]  fn;
        logic [4:0]  tgt;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ht;
        logic        h1;
        logic        h2;
        logic [15:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_buffer_if #(.FETCH_W(2), .DEPTH(8)) dif ();

    decode_buffer #(.FETCH_W(2), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          seq     = 0;
    logic [31:0] pc_base = 32'h1000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [5:0] op, input int st,
                                input int fn, input logic [4:0] tgt, input logic [4:0] r1,
                                input logic [4:0] r2, input logic ht, input logic h1,
                                input logic h2, input logic [15:0] imm);
        exp_t e;
        e = '{pc: pc, op: op, st: 4'(st), fn: 6'(fn), tgt: tgt, r1: r1, r2: r2,
              ht: ht, h1: h1, h2: h2, imm: imm};
        return e;
    endfunction

    // Hand-written decode table: instruction word and its required micro-op.
    task automatic make(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] pc,
                        output logic [31:0] instr, output exp_t e);
        case (kind)
            0: begin instr = {6'h09, rs, rt, imm}; e = mk(pc, 6'h09, 1, 0, rt, rs, 0, 1, 1, 0, imm); end
            1: begin instr = {6'h0C, rs, rt, imm}; e = mk(pc, 6'h0C, 1, 2, rt, rs, 0, 1, 1, 0, imm); end
            2: begin instr = {6'h04, rs, rt, imm}; e = mk(pc, 6'h04, 3, 3, 0, rs, rt, 0, 1, 1, imm); end
            3: begin instr = {6'h23, rs, rt, imm}; e = mk(pc, 6'h23, 4, 0, rt, rs, 0, 1, 1, 0, imm); end
            4: begin instr = {6'h2B, rs, rt, imm}; e = mk(pc, 6'h2B, 4, 1, 0, rs, rt, 0, 1, 1, imm); end
            5: begin instr = {6'h0F, rs, rt, imm}; e = mk(pc, 6'h0F, 3, 0, rt, 0, 0, 1, 0, 0, imm); end
            6: begin instr = {6'h00, rs, rt, rd, 5'd0, 6'h21}; e = mk(pc, 6'h00, 1, 0, rd, rs, rt, 1, 1, 1, 0); end
            7: begin instr = {6'h00, rs, rt, rd, 5'd0, 6'h24}; e = mk(pc, 6'h00, 1, 1, rd, rs, rt, 1, 1, 1, 0); end
            8: begin instr = {6'h00, rs, rt, rd, 5'd0, 6'h1A}; e = mk(pc, 6'h00, 2, 0, 0, rs, rt, 0, 1, 1, 0); end
            9: begin instr = {6'h00, rs, rt, rd, 5'd0, 6'h10}; e = mk(pc, 6'h00, 2, 1, rd, 0, 0, 1, 0, 0, 0); end
            default: begin instr = {6'h00, rs, rt, rd, 5'd0, 6'h12}; e = mk(pc, 6'h00, 2, 2, rd, 0, 0, 1, 0, 0, 0); end
        endcase
    endtask

    // Wait (bounded) for in_ready, present one packet for one edge, queue the kept lanes.
    task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] mask,
                        input logic [31:0] pc, input exp_t e0, input exp_t e1,
                        input logic k0, input logic k1);
        int n = 0;
        while (!dif.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_wait", int'(dif.in_ready), 1);
        dif.in_instr = {i1, i0};
        dif.in_mask  = mask;
        dif.in_pc    = pc;
        dif.in_valid = 1'b1;
        if (k0) exp_q.push_back(e0);
        if (k1) exp_q.push_back(e1);
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic next_pair(input logic [1:0] mask);
        logic [31:0] i0, i1;
        exp_t        e0, e1;
        make(seq % 11, 5'(seq), 5'((seq % 31) + 1), 5'(((seq * 7) % 31) + 1),
             16'(seq * 3 + 1), pc_base, i0, e0);
        make((seq + 1) % 11, 5'(seq + 1), 5'(((seq + 1) % 31) + 1),
             5'((((seq + 1) * 7) % 31) + 1), 16'((seq + 1) * 3 + 1), pc_base + 32'd4, i1, e1);
        send(i0, i1, mask, pc_base, e0, e1, mask[0], mask[1]);
        seq     += 2;
        pc_base += 32'd8;
    endtask

    task automatic drain();
        int n = 0;
        dif.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        dif.out_ready = 1'b0;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_count", int'(dif.count), 0);
    endtask

    // Monitor: every honored pop is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t act;
        exp_t req;
        if (rst_n && dif.out_valid && dif.out_ready && !dif.flush) begin
            act = '{pc: dif.out_pc, op: dif.out_operation, st: dif.out_rs_station,
                    fn: dif.out_alu_fn, tgt: dif.out_reg_target, r1: dif.out_reg_1,
                    r2: dif.out_reg_2, ht: dif.out_has_target, h1: dif.out_has_reg_1,
                    h2: dif.out_has_reg_2, imm: dif.out_immediate};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: actual %h required no entry", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL head_uop: actual %h required %h", act, req);
                end
            end
        end
    end

    initial begin
        logic [31:0] i0, i1;
        exp_t        e0, e1;
        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_mask   = '0;
        dif.in_pc     = '0;
        dif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("reset_count", int'(dif.count), 0);
        chk("reset_in_ready", int'(dif.in_ready), 1);
        chk("reset_out_valid", int'(dif.out_valid), 0);

        // addiu $2,$1,5 then lw $3,4($1)
        send(32'h24220005, 32'h8C230004, 2'b11, 32'h100,
             mk(32'h100, 6'h09, 1, 0, 2, 1, 0, 1, 1, 0, 16'h5),
             mk(32'h104, 6'h23, 4, 0, 3, 1, 0, 1, 1, 0, 16'h4), 1'b1, 1'b1);
        chk("first_count", int'(dif.count), 2);
        chk("first_out_valid", int'(dif.out_valid), 1);
        drain();

        // addu to $0 is a no-op; and $4 survives at pc+4
        e0 = mk(32'h200, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(32'h00220021, 32'h00222024, 2'b11, 32'h200, e0,
             mk(32'h204, 6'h00, 1, 1, 4, 1, 2, 1, 1, 1, 16'h0), 1'b0, 1'b1);
        chk("compact_count", int'(dif.count), 1);
        send(32'h24220005, 32'h8C230004, 2'b00, 32'h300, e0, e0, 1'b0, 1'b0);
        chk("mask_zero_count", int'(dif.count), 1);
        send(32'hFC221111, 32'hFC000000, 2'b11, 32'h400, e0, e0, 1'b0, 1'b0);
        chk("bad_opcode_count", int'(dif.count), 1);
        drain();

        // Fill and backpressure
        repeat (3) next_pair(2'b11);
        chk("fill6_in_ready", int'(dif.in_ready), 1);
        next_pair(2'b01);
        chk("fill7_count", int'(dif.count), 7);
        chk("fill7_in_ready", int'(dif.in_ready), 0);
        dif.in_instr  = 32'h24220005;
        dif.in_mask   = 2'b11;
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b1;
        tick();
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        chk("fill7_pop_no_accept", int'(dif.count), 6);
        next_pair(2'b11);
        chk("fill8_count", int'(dif.count), 8);
        chk("fill8_in_ready", int'(dif.in_ready), 0);
        dif.in_valid = 1'b1;
        tick();
        dif.in_valid = 1'b0;
        chk("fill8_no_overflow", int'(dif.count), 8);
        dif.out_ready = 1'b1;
        repeat (16) next_pair(2'b11);
        drain();

        // Simultaneous accept and pop at count 3
        next_pair(2'b11);
        next_pair(2'b01);
        chk("sim_count3", int'(dif.count), 3);
        dif.out_ready = 1'b1;
        next_pair(2'b11);
        dif.out_ready = 1'b0;
        chk("sim_count4", int'(dif.count), 4);
        drain();

        // Flush at count 5 with accept and pop requested
        next_pair(2'b11);
        next_pair(2'b11);
        next_pair(2'b01);
        chk("flush_pre_count", int'(dif.count), 5);
        dif.in_instr  = {32'h8C230004, 32'h24220005};
        dif.in_mask   = 2'b11;
        dif.in_pc     = 32'h900;
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b1;
        dif.flush     = 1'b1;
        tick();
        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        exp_q.delete();
        chk("flush_count", int'(dif.count), 0);
        chk("flush_out_valid", int'(dif.out_valid), 0);
        next_pair(2'b11);
        chk("post_flush_count", int'(dif.count), 2);
        drain();

        // Decode sweep with random register fields, streaming
        dif.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 11; k += 2) begin
                make(k, 5'($urandom), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                     16'($urandom), pc_base, i0, e0);
                make((k + 1) % 11, 5'($urandom), 5'($urandom_range(1, 31)),
                     5'($urandom_range(1, 31)), 16'($urandom), pc_base + 32'd4, i1, e1);
                send(i0, i1, 2'b11, pc_base, e0, e1, 1'b1, 1'b1);
                pc_base += 32'd8;
            end
        end
        drain();

        // Asynchronous reset mid-stream
        next_pair(2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", int'(dif.count), 0);
        chk("async_reset_out_valid", int'(dif.out_valid), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_reset_in_ready", int'(dif.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
